// File: rtl/wb_cmd_initiator.sv
// wb_cmd_initiator
// ----------------
// Single-outstanding Wishbone classic initiator. One command taken on the
// valid/ready command interface becomes exactly one Wishbone read or write
// cycle. The result comes back on a valid/ready response interface. A
// watchdog aborts a cycle that is not acknowledged within TIMEOUT cycles.
//
// Parameters:
//   TIMEOUT - cycles stb may stay high waiting for ack (0 disables watchdog)
//   TO_BITS - watchdog counter width, TIMEOUT < 2**TO_BITS
//
// Optional feature (macro WB_CMD_INITIATOR_ERR_EN):
//   Adds input wbm_err_i. An err terminates the cycle with rsp_err = 1 and
//   takes priority over a simultaneous ack.
//
// Ports:
//   wb_clk_i, wb_rst_i                  clock, synchronous active-high reset
//   cmd_valid/cmd_ready                 command handshake
//   cmd_we, cmd_adr, cmd_dat, cmd_sel   command fields
//   rsp_valid/rsp_ready                 response handshake
//   rsp_dat, rsp_err                    read data / abort flag
//   busy                                high whenever not idle
//   wbm_cyc_o, wbm_stb_o, wbm_we_o,
//   wbm_sel_o, wbm_adr_o, wbm_dat_o     Wishbone initiator outputs
//   wbm_dat_i, wbm_ack_i (, wbm_err_i)  Wishbone responder inputs
module wb_cmd_initiator #(
    parameter int TIMEOUT = 16,
    parameter int TO_BITS = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    input  logic [3:0]  cmd_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        busy,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
`ifdef WB_CMD_INITIATOR_ERR_EN
    input  logic        wbm_err_i,
`endif
    input  logic        wbm_ack_i
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Counter value on the last permitted stb cycle; counter starts at 0 on
    // the first stb cycle, so stb is high exactly TIMEOUT cycles.
    localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'(TIMEOUT - 1);

    logic [1:0]         state;
    logic [TO_BITS-1:0] to_cnt;
    logic               bus_err;
    logic               bus_done;
    logic               to_hit;

    // Responder termination: err (when present) ends the cycle like ack but
    // flags an error, and wins over a simultaneous ack.
    always_comb begin
`ifdef WB_CMD_INITIATOR_ERR_EN
        bus_err = wbm_err_i;
`else
        bus_err = 1'b0;
`endif
        bus_done = wbm_ack_i || bus_err;
        to_hit   = (TIMEOUT != 0) && (to_cnt == TO_LAST);
    end

    // Main sequencer: IDLE accepts a command, BUS runs the Wishbone cycle
    // until ack/err/watchdog, RESP holds the result until it is consumed.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= ST_IDLE;
            to_cnt    <= '0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_dat   <= '0;
            rsp_err   <= 1'b0;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= '0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        wbm_we_o  <= cmd_we;
                        wbm_adr_o <= cmd_adr;
                        wbm_dat_o <= cmd_dat;
                        wbm_sel_o <= cmd_sel;
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        to_cnt    <= '0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    if (bus_done) begin
                        // Ack beats the watchdog on the same cycle.
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= bus_err;
                        rsp_dat   <= (bus_err || wbm_we_o) ? 32'd0 : wbm_dat_i;
                        state     <= ST_RESP;
                    end else if (to_hit) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_dat   <= '0;
                        state     <= ST_RESP;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    rsp_valid <= 1'b0;
                    wbm_cyc_o <= 1'b0;
                    wbm_stb_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_cmd_initiator.sv
// tb_wb_cmd_initiator
// -------------------
// Bench for wb_cmd_initiator. The main instance (TIMEOUT=16) is compared
// every cycle against a transaction-level expectation; two extra instances
// cover TIMEOUT=4 (ack on the watchdog cycle) and TIMEOUT=0 (no watchdog).
module tb_wb_cmd_initiator;

    localparam int TB_TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_we;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_ready;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;
`ifdef WB_CMD_INITIATOR_ERR_EN
    logic        wbm_err_i;
`endif

    logic        cmd_ready, rsp_valid, rsp_err, busy;
    logic [31:0] rsp_dat;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;

    logic        v4, ack4;
    logic        cmd_ready4, rsp_valid4, rsp_err4, busy4;
    logic [31:0] rsp_dat4;
    logic        cyc4, stb4, we4;
    logic [3:0]  sel4;
    logic [31:0] adr4, dato4;

    logic        v0;
    logic        cmd_ready0, rsp_valid0, rsp_err0, busy0;
    logic [31:0] rsp_dat0;
    logic        cyc0, stb0, we0;
    logic [3:0]  sel0;
    logic [31:0] adr0, dato0;

    // expected outputs of the main instance
    logic        model_on = 1'b0;
    logic        exp_cmd_ready, exp_busy, exp_cyc, exp_stb, exp_we;
    logic        exp_rsp_valid, exp_rsp_err;
    logic [3:0]  exp_sel;
    logic [31:0] exp_adr, exp_dat, exp_rsp_dat;

    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc_count = 0;
    int          accept_at = 0;
    int          rsp_at = -1;
    int          stb_cycles = 0;
    logic [31:0] last_rsp_dat;
    logic        last_rsp_err;

    always #5 clk = ~clk;

    wb_cmd_initiator #(.TIMEOUT(TB_TIMEOUT), .TO_BITS(8)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
        .rsp_err(rsp_err), .busy(busy),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_dat_i(wbm_dat_i),
`ifdef WB_CMD_INITIATOR_ERR_EN
        .wbm_err_i(wbm_err_i),
`endif
        .wbm_ack_i(wbm_ack_i)
    );

    wb_cmd_initiator #(.TIMEOUT(4), .TO_BITS(8)) dut4 (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .cmd_valid(v4), .cmd_ready(cmd_ready4), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat4),
        .rsp_err(rsp_err4), .busy(busy4),
        .wbm_cyc_o(cyc4), .wbm_stb_o(stb4), .wbm_we_o(we4),
        .wbm_sel_o(sel4), .wbm_adr_o(adr4), .wbm_dat_o(dato4),
        .wbm_dat_i(wbm_dat_i),
`ifdef WB_CMD_INITIATOR_ERR_EN
        .wbm_err_i(1'b0),
`endif
        .wbm_ack_i(ack4)
    );

    wb_cmd_initiator #(.TIMEOUT(0), .TO_BITS(8)) dut0 (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .cmd_valid(v0), .cmd_ready(cmd_ready0), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat0),
        .rsp_err(rsp_err0), .busy(busy0),
        .wbm_cyc_o(cyc0), .wbm_stb_o(stb0), .wbm_we_o(we0),
        .wbm_sel_o(sel0), .wbm_adr_o(adr0), .wbm_dat_o(dato0),
        .wbm_dat_i(wbm_dat_i),
`ifdef WB_CMD_INITIATOR_ERR_EN
        .wbm_err_i(1'b0),
`endif
        .wbm_ack_i(1'b0)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    endtask

    // Every-cycle comparison of the main instance against the expectation.
    always @(negedge clk) begin
        if (model_on) begin
            checkOutput("cmd_ready", {31'd0, cmd_ready}, {31'd0, exp_cmd_ready});
            checkOutput("busy", {31'd0, busy}, {31'd0, exp_busy});
            checkOutput("cyc", {31'd0, wbm_cyc_o}, {31'd0, exp_cyc});
            checkOutput("stb", {31'd0, wbm_stb_o}, {31'd0, exp_stb});
            checkOutput("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_rsp_valid});
            if (exp_cyc) begin
                checkOutput("wbm_we", {31'd0, wbm_we_o}, {31'd0, exp_we});
                checkOutput("wbm_sel", {28'd0, wbm_sel_o}, {28'd0, exp_sel});
                checkOutput("wbm_adr", wbm_adr_o, exp_adr);
                checkOutput("wbm_dat", wbm_dat_o, exp_dat);
            end
            if (exp_rsp_valid) begin
                checkOutput("rsp_dat", rsp_dat, exp_rsp_dat);
                checkOutput("rsp_err", {31'd0, rsp_err}, {31'd0, exp_rsp_err});
            end
        end
    end

    // Observed timing of the main instance: stb length and accept-to-response.
    always @(negedge clk) begin
        cyc_count++;
        if (cmd_valid && cmd_ready) begin
            accept_at  = cyc_count;
            stb_cycles = 0;
            rsp_at     = -1;
        end else if (wbm_stb_o) begin
            stb_cycles++;
        end
        if (rsp_valid && rsp_at < 0) rsp_at = cyc_count;
    end

    task automatic setIdleExpect();
        exp_cmd_ready = 1'b1;
        exp_busy      = 1'b0;
        exp_cyc       = 1'b0;
        exp_stb       = 1'b0;
        exp_rsp_valid = 1'b0;
    endtask

    // One command on the main instance. ack_cycle/err_cycle give the stb
    // cycle (1-based, 0 = never) on which the responder answers; rst_cycle
    // pulses reset on that stb cycle instead of completing.
    task automatic applyStimulus(input logic we, input logic [31:0] adr,
                                 input logic [31:0] dat, input logic [3:0] sel,
                                 input int ack_cycle, input int err_cycle,
                                 input logic [31:0] rdata, input int rsp_wait,
                                 input int rst_cycle);
        int   end_cycle;
        logic will_err;
        end_cycle = TB_TIMEOUT;
        will_err  = 1'b1;
        if (ack_cycle > 0 && ack_cycle <= TB_TIMEOUT) begin
            end_cycle = ack_cycle;
            will_err  = 1'b0;
        end
        if (err_cycle > 0 && err_cycle <= end_cycle) begin
            end_cycle = err_cycle;
            will_err  = 1'b1;
        end

        cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_we = ~we; cmd_adr = $urandom; cmd_dat = $urandom; cmd_sel = ~sel;
        exp_cmd_ready = 1'b0; exp_busy = 1'b1; exp_cyc = 1'b1; exp_stb = 1'b1;
        exp_we = we; exp_adr = adr; exp_dat = dat; exp_sel = sel;

        for (int k = 1; k <= end_cycle; k++) begin
            wbm_ack_i = (k == ack_cycle);
`ifdef WB_CMD_INITIATOR_ERR_EN
            wbm_err_i = (k == err_cycle);
`endif
            wbm_dat_i = (k == ack_cycle) ? rdata : $urandom;
            rst = (k == rst_cycle);
            @(posedge clk); #1;
            wbm_ack_i = 1'b0;
`ifdef WB_CMD_INITIATOR_ERR_EN
            wbm_err_i = 1'b0;
`endif
            if (k == rst_cycle) begin
                rst = 1'b0;
                setIdleExpect();
                return;
            end
            if (k == end_cycle) begin
                exp_cyc = 1'b0; exp_stb = 1'b0; exp_rsp_valid = 1'b1;
                exp_rsp_err = will_err;
                exp_rsp_dat = (will_err || we) ? 32'd0 : rdata;
            end
        end
        last_rsp_dat = rsp_dat;
        last_rsp_err = rsp_err;

        // backpressure, with stray acks that must be ignored
        for (int w = 0; w < rsp_wait; w++) begin
            wbm_ack_i = w[0];
            wbm_dat_i = $urandom;
            @(posedge clk); #1;
        end
        wbm_ack_i = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        setIdleExpect();
        wbm_ack_i = 1'b1;
        @(posedge clk); #1;
        wbm_ack_i = 1'b0;
    endtask

    initial begin
        int held;
        int saw_rsp;
        rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0;
        cmd_sel = '0; rsp_ready = 1'b0; wbm_dat_i = '0; wbm_ack_i = 1'b0;
        v4 = 1'b0; ack4 = 1'b0; v0 = 1'b0;
`ifdef WB_CMD_INITIATOR_ERR_EN
        wbm_err_i = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        checkOutput("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_cyc", {31'd0, wbm_cyc_o}, 32'd0);
        checkOutput("rst_stb", {31'd0, wbm_stb_o}, 32'd0);
        checkOutput("rst_we", {31'd0, wbm_we_o}, 32'd0);
        checkOutput("rst_sel", {28'd0, wbm_sel_o}, 32'd0);
        checkOutput("rst_adr", wbm_adr_o, 32'd0);
        checkOutput("rst_dat_o", wbm_dat_o, 32'd0);
        checkOutput("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("rst_rsp_dat", rsp_dat, 32'd0);
        checkOutput("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        setIdleExpect();
        model_on = 1'b1;

        $display("[TB] write, ack on 2nd stb cycle");
        applyStimulus(1'b1, 32'h3000_0000, 32'h1234_5678, 4'hF, 2, 0, 32'hDEAD_BEEF, 0, 0);
        checkOutput("wr_latency", rsp_at - accept_at, 32'd3);
        checkOutput("wr_stb_cycles", stb_cycles, 32'd2);
        checkOutput("wr_rsp_dat", last_rsp_dat, 32'd0);
        checkOutput("wr_rsp_err", {31'd0, last_rsp_err}, 32'd0);

        $display("[TB] read, immediate ack");
        applyStimulus(1'b0, 32'h3000_0004, 32'h0, 4'h3, 1, 0, 32'h0000_00A5, 0, 0);
        checkOutput("rd_rsp_dat", last_rsp_dat, 32'h0000_00A5);
        checkOutput("rd_rsp_err", {31'd0, last_rsp_err}, 32'd0);
        checkOutput("rd_stb_cycles", stb_cycles, 32'd1);

        $display("[TB] timeout, no ack");
        applyStimulus(1'b0, 32'h3000_0008, 32'h0, 4'hF, 0, 0, 32'h1111_1111, 2, 0);
        checkOutput("to_stb_cycles", stb_cycles, 32'd16);
        checkOutput("to_rsp_err", {31'd0, last_rsp_err}, 32'd1);
        checkOutput("to_rsp_dat", last_rsp_dat, 32'd0);
        checkOutput("to_latency", rsp_at - accept_at, 32'd17);

        $display("[TB] response backpressure");
        applyStimulus(1'b0, 32'h3000_000C, 32'h0, 4'h5, 3, 0, 32'hCAFE_F00D, 5, 0);
        checkOutput("bp_rsp_dat", last_rsp_dat, 32'hCAFE_F00D);

        $display("[TB] ack on the last permitted stb cycle");
        applyStimulus(1'b0, 32'h3000_0010, 32'h0, 4'hF, 16, 0, 32'h0BAD_C0DE, 1, 0);
        checkOutput("edge_rsp_err", {31'd0, last_rsp_err}, 32'd0);
        checkOutput("edge_rsp_dat", last_rsp_dat, 32'h0BAD_C0DE);
        checkOutput("edge_stb_cycles", stb_cycles, 32'd16);

        $display("[TB] reset on 3rd stb cycle");
        applyStimulus(1'b1, 32'h3000_0014, 32'hAAAA_5555, 4'hF, 0, 0, 32'h0, 0, 3);
        checkOutput("mid_rst_cyc", {31'd0, wbm_cyc_o}, 32'd0);
        checkOutput("mid_rst_adr", wbm_adr_o, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        applyStimulus(1'b1, 32'h3000_0018, 32'h0F0F_0F0F, 4'h1, 1, 0, 32'h0, 1, 0);
        checkOutput("post_rst_err", {31'd0, last_rsp_err}, 32'd0);

`ifdef WB_CMD_INITIATOR_ERR_EN
        $display("[TB] err with ack, err alone");
        applyStimulus(1'b0, 32'h3000_001C, 32'h0, 4'hF, 2, 2, 32'h0000_0055, 0, 0);
        checkOutput("err_ack_err", {31'd0, last_rsp_err}, 32'd1);
        checkOutput("err_ack_dat", last_rsp_dat, 32'd0);
        applyStimulus(1'b1, 32'h3000_0020, 32'h7, 4'hF, 0, 1, 32'h0, 0, 0);
        checkOutput("err_only_err", {31'd0, last_rsp_err}, 32'd1);
`endif

        $display("[TB] TIMEOUT=4 instance");
        cmd_we = 1'b0; cmd_adr = 32'h3000_0100; cmd_sel = 4'hF; v4 = 1'b1;
        @(posedge clk); #1;
        v4 = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            ack4 = (k == 4);
            wbm_dat_i = (k == 4) ? 32'h0000_005A : 32'hFFFF_FFFF;
            @(posedge clk); #1;
        end
        ack4 = 1'b0;
        checkOutput("t4_ack_valid", {31'd0, rsp_valid4}, 32'd1);
        checkOutput("t4_ack_err", {31'd0, rsp_err4}, 32'd0);
        checkOutput("t4_ack_dat", rsp_dat4, 32'h0000_005A);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        checkOutput("t4_cmd_ready", {31'd0, cmd_ready4}, 32'd1);
        v4 = 1'b1;
        @(posedge clk); #1;
        v4 = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            checkOutput("t4_to_stb", {31'd0, stb4}, 32'd1);
            @(posedge clk); #1;
        end
        checkOutput("t4_to_stb_drop", {31'd0, stb4}, 32'd0);
        checkOutput("t4_to_err", {31'd0, rsp_err4}, 32'd1);
        checkOutput("t4_to_dat", rsp_dat4, 32'd0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;

        $display("[TB] TIMEOUT=0 instance");
        held = 0;
        saw_rsp = 0;
        v0 = 1'b1;
        @(posedge clk); #1;
        v0 = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            if (stb0 && cyc0) held++;
            if (rsp_valid0) saw_rsp++;
            @(posedge clk); #1;
        end
        checkOutput("t0_stb_held", held, 32'd1000);
        checkOutput("t0_no_rsp", saw_rsp, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("t0_rst_stb", {31'd0, stb0}, 32'd0);

        model_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_cmd_initiator.md
Name: wb_cmd_initiator

Overview:
- Single-outstanding Wishbone (classic, non-pipelined) bus initiator for the user project area.
- Converts a valid/ready command interface into one Wishbone read or write cycle.
- Returns the result on a valid/ready response interface.
- Drives user-area Wishbone responders, such as the counter peripheral, from local logic or LA probes; includes a bus-timeout watchdog.

Parameters:
- TIMEOUT, 16: cycles a cycle may wait for ack before abort. 0 disables the watchdog.
- TO_BITS, 8: width of the timeout counter. Must satisfy TIMEOUT < 2^TO_BITS.

Ports:
- wb_clk_i  input  1  clock; all logic on rising edge
- wb_rst_i  input  1  synchronous reset, active-high
- cmd_valid  input  1  command present
- cmd_ready  output  1  block can accept a command
- cmd_we  input  1  1=write, 0=read
- cmd_adr  input  32  byte address
- cmd_dat  input  32  write data
- cmd_sel  input  4  byte selects
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer takes response
- rsp_dat  output  32  read data (0 for writes and aborts)
- rsp_err  output  1  1=cycle aborted
- busy  output  1  high in any state other than IDLE
- wbm_cyc_o  output  1  Wishbone cycle
- wbm_stb_o  output  1  Wishbone strobe
- wbm_we_o  output  1  write enable
- wbm_sel_o  output  4  byte selects
- wbm_adr_o  output  32  address
- wbm_dat_o  output  32  write data
- wbm_dat_i  input  32  read data from responder
- wbm_ack_i  input  1  cycle acknowledge

Behaviour:
- Reset values (all outputs registered):
  - cyc/stb/we = 0; sel = 0; adr/dat_o = 0
  - rsp_valid = 0; rsp_dat = 0; rsp_err = 0
  - busy = 0; cmd_ready = 1; state = IDLE; timeout counter = 0
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid && cmd_ready at edge N: register cmd fields onto wbm_* outputs; cyc = stb = 1 from N+1; counter cleared; go to BUS.
- BUS:
  - cmd_ready = 0. cyc/stb/we/sel/adr/dat_o held stable.
  - Counter increments each cycle while ack is not sampled.
  - ack sampled high: cyc/stb drop on that edge; rsp_dat = wbm_dat_i for reads, 0 for writes; rsp_err = 0; rsp_valid = 1; go to RESP.
  - TIMEOUT ≠ 0, counter == TIMEOUT-1, ack low: cyc/stb drop; rsp_err = 1; rsp_dat = 0; rsp_valid = 1; go to RESP. stb is therefore high exactly TIMEOUT cycles.
  - ack and timeout on the same cycle: ack wins, normal completion.
- RESP:
  - rsp_valid and rsp_* held stable until rsp_ready sampled high, then rsp_valid = 0 and go to IDLE.
  - cmd_ready rises the cycle after the handshake. No back-to-back overlap; max throughput is one command per 4 cycles with a 1-cycle-ack responder.
- Latency: accept at N, stb at N+1; a registered responder acks at N+2 (earliest); rsp_valid at N+3.
- wbm_ack_i outside BUS is ignored, with no state change.
- wb_rst_i in any state, including mid-cycle: next edge forces reset values; cyc/stb drop immediately; no response is produced; a pending response is discarded.
- cmd_sel is passed through unmodified for reads as well as writes.

Optional Feature:
- Macro: WB_CMD_INITIATOR_ERR_EN.
- Defined:
  - Adds input wbm_err_i (1 bit).
  - In BUS, err sampled high terminates the cycle like ack, but rsp_err = 1 and rsp_dat = 0.
  - ack and err both high: err wins.
  - Timeout and err responses are indistinguishable by design.
- Undefined: no wbm_err_i port; only the timeout sets rsp_err.

Test Plan:
- Write, responder acks 1 cycle after stb: cmd we=1, adr=0x3000_0000, dat=0x1234_5678, sel=0xF accepted at N.
  - Required: cyc/stb high at N+1 with those values on wbm_* outputs.
  - Required: rsp_valid at N+3 with rsp_err=0, rsp_dat=0.
- Read: responder returns 0x0000_00A5 with ack.
  - Required: rsp_dat=0x0000_00A5, rsp_err=0; cyc low the cycle after ack.
- Timeout, TIMEOUT=16, no ack:
  - Required: stb high exactly 16 cycles, then rsp_valid with rsp_err=1, rsp_dat=0.
  - Repeat with TIMEOUT=0: stb held ≥1000 cycles with no response.
- Response backpressure: rsp_ready low for 5 cycles.
  - Required: rsp_valid/rsp_dat stable; cmd_ready=0 throughout; cmd_ready=1 one cycle after rsp_ready.
- Reset mid-BUS: wb_rst_i pulsed on the 3rd stb cycle.
  - Required: cyc/stb=0 the next cycle; rsp_valid never asserts; a new command then completes normally.
- Ack on timeout cycle (TIMEOUT=4, ack on 4th stb cycle): rsp_err=0. With WB_CMD_INITIATOR_ERR_EN, err with ack: rsp_err=1.
